// File: rtl/processorci_bus_pkg.sv
// ----------------------------------------------------------------------------
// processorci_bus_pkg
// Shared definitions for the NERV data-memory bridge and its helpers.
//   - bridge_state_t    : bridge controller states
//   - ERR_RDATA_DEFAULT : read value handed back to the core when a bus access
//                         times out
//   - BUS_BYTES         : number of byte lanes on the 32-bit data path
//   - STRB_NONE/FULL    : strobe patterns that select a plain read or a
//                         full-word write
//   - isBusState()      : true for states that hold a request on the bus
// ----------------------------------------------------------------------------
package processorci_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } bridge_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;
    localparam int          BUS_BYTES         = 4;
    localparam logic [3:0]  STRB_NONE         = 4'h0;
    localparam logic [3:0]  STRB_FULL         = 4'hF;

    // States in which the bridge is waiting on the external bus.
    function automatic logic isBusState(input bridge_state_t state);
        return (state == READ) || (state == RMW_READ) || (state == WRITE);
    endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// ----------------------------------------------------------------------------
// dmem_byte_merge
// Purely combinational byte-lane merge used for partial writes: every byte
// lane whose strobe bit is set takes the new word's byte, all other lanes
// keep the old word's byte.
// Ports:
//   i_oldWord    [31:0] word currently held in memory
//   i_newWord    [31:0] write data from the core
//   i_strobe     [3:0]  byte enables, bit i selects lane i
//   o_mergedWord [31:0] resulting word to write back
// ----------------------------------------------------------------------------
module dmem_byte_merge
    import processorci_bus_pkg::*;
(
    input  logic [31:0] i_oldWord,
    input  logic [31:0] i_newWord,
    input  logic [3:0]  i_strobe,
    output logic [31:0] o_mergedWord
);

    // Start from the old word and overwrite only the enabled lanes.
    always_comb begin
        o_mergedWord = i_oldWord;
        for (int i = 0; i < BUS_BYTES; i++) begin
            if (i_strobe[i]) begin
                o_mergedWord[8*i +: 8] = i_newWord[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/nerv_dmem_bridge.sv
// ----------------------------------------------------------------------------
// nerv_dmem_bridge
// Adapts the NERV core's single-cycle data-memory port to a request/response
// bus. Reads issue one bus read; full-word writes issue one bus write; partial
// writes do a read-modify-write. A bus phase that waits TIMEOUT_CYCLES cycles
// without a response is abandoned and flags a sticky error.
// Parameters:
//   TIMEOUT_CYCLES  maximum cycles spent in one bus phase (2..65535)
//   ERR_RDATA       read data returned to the core on a timed-out read
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dmem_valid/addr/wstrb/wdata core request (wstrb==0 is a read)
//   dmem_rdata                 read data back to the core
//   stall                      holds the core while a request is in flight
//   mem_read, mem_write        registered bus requests
//   mem_address                registered word-aligned bus address
//   mem_write_data             registered bus write data
//   mem_read_data              bus read data, valid with mem_response
//   mem_response               bus completion of the current phase
//   error                      sticky timeout flag
// ----------------------------------------------------------------------------
module nerv_dmem_bridge
    import processorci_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_response,
    output logic        error
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    bridge_state_t r_state;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [15:0]   r_waitCount;
    logic          r_memRead;
    logic          r_memWrite;
    logic [31:0]   r_memAddress;
    logic [31:0]   r_memWriteData;
    logic [31:0]   r_dmemRdata;
    logic          r_error;

    logic [31:0]   w_mergedWord;
    logic          w_waitExpired;
    logic          w_unusedAddrBits;

    // The bus is word addressed, so the byte offset only matters through the
    // strobes the core already supplies.
    assign w_unusedAddrBits = ^dmem_addr[1:0];

    assign w_waitExpired = (r_waitCount == WAIT_LAST);

    // Partial writes combine the fresh bus word with the latched core data.
    dmem_byte_merge u_merge (
        .i_oldWord    (mem_read_data),
        .i_newWord    (r_wdata),
        .i_strobe     (r_wstrb),
        .o_mergedWord (w_mergedWord)
    );

    // Controller: each bus phase ends on the first cycle with a response, or
    // is abandoned once the wait counter has spent its budget. A response
    // always wins over an expiring counter in the same cycle. The bus request
    // flags are updated on the same edge as the state so they track it
    // exactly without any combinational decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_wstrb        <= '0;
            r_wdata        <= '0;
            r_waitCount    <= '0;
            r_memRead      <= 1'b0;
            r_memWrite     <= 1'b0;
            r_memAddress   <= '0;
            r_memWriteData <= '0;
            r_dmemRdata    <= '0;
            r_error        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dmem_valid) begin
                        r_wstrb      <= dmem_wstrb;
                        r_wdata      <= dmem_wdata;
                        r_memAddress <= {dmem_addr[31:2], 2'b00};
                        r_waitCount  <= '0;
                        if (dmem_wstrb == STRB_NONE) begin
                            r_state   <= READ;
                            r_memRead <= 1'b1;
                        end else if (dmem_wstrb == STRB_FULL) begin
                            r_state        <= WRITE;
                            r_memWrite     <= 1'b1;
                            r_memWriteData <= dmem_wdata;
                        end else begin
                            r_state   <= RMW_READ;
                            r_memRead <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_response) begin
                        r_dmemRdata <= mem_read_data;
                        r_memRead   <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_waitExpired) begin
                        r_dmemRdata <= ERR_RDATA;
                        r_error     <= 1'b1;
                        r_memRead   <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_waitCount <= r_waitCount + 16'd1;
                    end
                end
                RMW_READ: begin
                    if (mem_response) begin
                        r_memWriteData <= w_mergedWord;
                        r_memRead      <= 1'b0;
                        r_memWrite     <= 1'b1;
                        r_waitCount    <= '0;
                        r_state        <= WRITE;
                    end else if (w_waitExpired) begin
                        // The write half is dropped; the core sees no data.
                        r_error   <= 1'b1;
                        r_memRead <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_waitCount <= r_waitCount + 16'd1;
                    end
                end
                WRITE: begin
                    if (mem_response || w_waitExpired) begin
                        r_memWrite <= 1'b0;
                        r_state    <= DONE;
                        if (!mem_response) begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_waitCount <= r_waitCount + 16'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                end
            endcase
        end
    end

    // The core must be held in the very cycle it raises a request, before
    // the registered state has moved out of IDLE.
    assign stall = ((r_state == IDLE) && dmem_valid) || isBusState(r_state);

    assign dmem_rdata     = r_dmemRdata;
    assign mem_read       = r_memRead;
    assign mem_write      = r_memWrite;
    assign mem_address    = r_memAddress;
    assign mem_write_data = r_memWriteData;
    assign error          = r_error;

endmodule

// File: tb/tb_nerv_dmem_bridge.sv
// ----------------------------------------------------------------------------
// tb_nerv_dmem_bridge
// Drives the bridge from a per-cycle plan built by a transaction-level model
// (memory array, response delays, timeout budget) and compares every planned
// cycle against the DUT, plus a few literal scenario expectations.
// ----------------------------------------------------------------------------
module tb_nerv_dmem_bridge;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk;
    logic        reset;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic        error;

    nerv_dmem_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_valid     (dmem_valid),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_response   (mem_response),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One planned cycle: the inputs to drive and the outputs the model expects.
    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        resp;
        logic [31:0] rdata;
        logic        eStall;
        logic        eRead;
        logic        eWrite;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eRdata;
        logic        eError;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        curRec;
    int          recSeq;
    int          checksTotal;
    int          checksPassed;
    logic [31:0] modelRdata;
    logic        modelError;
    logic [31:0] memArr[logic [31:0]];

    int          readCycles;
    int          writeCycles;
    int          stallCycles;
    int          lastGap;
    int          idleRun;
    logic [31:0] lastReadAddr;
    logic [31:0] lastWriteAddr;
    logic [31:0] lastWriteData;

    // Comparison helpers shared by the per-cycle checker and literal checks.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] memGet(input logic [31:0] a);
        if (!memArr.exists(a)) memArr[a] = $urandom;
        return memArr[a];
    endfunction

    // A cycle where the bridge is idle; unused inputs carry random noise,
    // including stray bus responses that must be ignored.
    function automatic cyc_t idleRec();
        cyc_t r;
        r.rst    = 1'b0;
        r.valid  = 1'b0;
        r.addr   = $urandom;
        r.wstrb  = 4'($urandom);
        r.wdata  = $urandom;
        r.resp   = 1'($urandom_range(0, 1));
        r.rdata  = $urandom;
        r.eStall = 1'b0;
        r.eRead  = 1'b0;
        r.eWrite = 1'b0;
        r.eAddr  = '0;
        r.eWdata = '0;
        r.eRdata = modelRdata;
        r.eError = modelError;
        return r;
    endfunction

    task automatic addGap(input int n);
        for (int i = 0; i < n; i++) plan.push_back(idleRec());
    endtask

    task automatic addReset();
        cyc_t r;
        r        = idleRec();
        r.rst    = 1'b1;
        r.valid  = 1'($urandom_range(0, 1));
        r.eStall = r.valid;
        plan.push_back(r);
        modelRdata = '0;
        modelError = 1'b0;
    endtask

    // Transaction model: a bus phase lasts until the response at wait index d,
    // or TMO cycles if d never falls inside the budget. resetAt (bus-cycle
    // index, -1 for none) aborts the transaction with a coincident response.
    task automatic addTxn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                          input int d1, input int d2, input int resetAt, input logic doneValid);
        cyc_t        r;
        logic [31:0] aligned;
        logic [31:0] oldWord;
        logic [31:0] newWord;
        logic [31:0] mask;
        int          n;
        int          busIdx;
        logic        isRead;
        logic        isFull;
        logic        timedOut;
        aligned  = {addr[31:2], 2'b00};
        isRead   = (strb == 4'h0);
        isFull   = (strb == 4'hF);
        busIdx   = 0;
        timedOut = 1'b0;
        oldWord  = '0;
        r        = idleRec();
        r.valid  = 1'b1;
        r.addr   = addr;
        r.wstrb  = strb;
        r.wdata  = wdata;
        r.eStall = 1'b1;
        plan.push_back(r);
        if (!isFull) begin
            oldWord = memGet(aligned);
            n = (d1 < TMO) ? d1 + 1 : TMO;
            for (int i = 0; i < n; i++) begin
                r        = idleRec();
                r.valid  = 1'($urandom_range(0, 1));
                r.eStall = 1'b1;
                r.eRead  = 1'b1;
                r.eAddr  = aligned;
                r.resp   = (i == d1);
                r.rdata  = (i == d1) ? oldWord : $urandom;
                if (busIdx == resetAt) begin
                    r.rst   = 1'b1;
                    r.resp  = 1'b1;
                    plan.push_back(r);
                    modelRdata = '0;
                    modelError = 1'b0;
                    return;
                end
                plan.push_back(r);
                busIdx++;
            end
            if (d1 >= TMO) begin
                timedOut   = 1'b1;
                modelError = 1'b1;
                if (isRead) modelRdata = ERR;
            end else if (isRead) begin
                modelRdata = oldWord;
            end
        end
        if (!isRead && !timedOut) begin
            mask    = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            newWord = isFull ? wdata : ((oldWord & ~mask) | (wdata & mask));
            n = (d2 < TMO) ? d2 + 1 : TMO;
            for (int i = 0; i < n; i++) begin
                r        = idleRec();
                r.valid  = 1'($urandom_range(0, 1));
                r.eStall = 1'b1;
                r.eWrite = 1'b1;
                r.eAddr  = aligned;
                r.eWdata = newWord;
                r.resp   = (i == d2);
                if (busIdx == resetAt) begin
                    r.rst   = 1'b1;
                    r.resp  = 1'b1;
                    plan.push_back(r);
                    modelRdata = '0;
                    modelError = 1'b0;
                    return;
                end
                plan.push_back(r);
                busIdx++;
            end
            if (d2 >= TMO) modelError = 1'b1;
            else memArr[aligned] = newWord;
        end
        r       = idleRec();
        r.valid = doneValid;
        plan.push_back(r);
    endtask

    // Plays the plan one record per cycle, then lets the last record be
    // sampled and parks the inputs in a quiet idle state.
    task automatic applyStimulus();
        cyc_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            @(posedge clk);
            #1;
            reset         = r.rst;
            dmem_valid    = r.valid;
            dmem_addr     = r.addr;
            dmem_wstrb    = r.wstrb;
            dmem_wdata    = r.wdata;
            mem_response  = r.resp;
            mem_read_data = r.rdata;
            curRec        = r;
            recSeq++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        dmem_valid   = 1'b0;
        mem_response = 1'b0;
    endtask

    // Per-cycle compare against the planned expectations, plus running
    // observations used by the literal scenario checks.
    task automatic compareLoop();
        int   seenSeq;
        logic bus;
        logic prevBus;
        seenSeq = 0;
        prevBus = 1'b0;
        forever begin
            @(negedge clk);
            bus = (mem_read === 1'b1) || (mem_write === 1'b1);
            if (mem_read === 1'b1) begin
                readCycles++;
                lastReadAddr = mem_address;
            end
            if (mem_write === 1'b1) begin
                writeCycles++;
                lastWriteAddr = mem_address;
                lastWriteData = mem_write_data;
            end
            if (stall === 1'b1) stallCycles++;
            if (bus && !prevBus) lastGap = idleRun;
            if (bus) idleRun = 0;
            else idleRun++;
            prevBus = bus;
            if (recSeq != seenSeq) begin
                seenSeq = recSeq;
                checkBit("stall", stall, curRec.eStall);
                checkBit("mem_read", mem_read, curRec.eRead);
                checkBit("mem_write", mem_write, curRec.eWrite);
                checkOutput("dmem_rdata", dmem_rdata, curRec.eRdata);
                checkBit("error", error, curRec.eError);
                if (curRec.eRead || curRec.eWrite)
                    checkOutput("mem_address", mem_address, curRec.eAddr);
                if (curRec.eWrite)
                    checkOutput("mem_write_data", mem_write_data, curRec.eWdata);
            end
        end
    endtask

    function automatic int pickDelay();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(6, 10));
        return int'($urandom_range(0, 3));
    endfunction

    // Main sequence: reset, directed scenarios with literal expectations,
    // then randomized traffic checked purely against the model.
    initial begin
        int          s0;
        int          r0;
        int          w0;
        int          kind;
        logic [3:0]  strb;
        logic [31:0] addr;
        checksTotal   = 0;
        checksPassed  = 0;
        recSeq        = 0;
        modelRdata    = '0;
        modelError    = 1'b0;
        readCycles    = 0;
        writeCycles   = 0;
        stallCycles   = 0;
        lastGap       = 0;
        idleRun       = 0;
        lastReadAddr  = '0;
        lastWriteAddr = '0;
        lastWriteData = '0;
        curRec        = '0;
        reset         = 1'b1;
        dmem_valid    = 1'b0;
        dmem_addr     = '0;
        dmem_wstrb    = '0;
        dmem_wdata    = '0;
        mem_read_data = '0;
        mem_response  = 1'b0;
        fork
            compareLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkBit("reset_stall", stall, 1'b0);
        checkBit("reset_mem_read", mem_read, 1'b0);
        checkBit("reset_mem_write", mem_write, 1'b0);
        checkOutput("reset_mem_address", mem_address, 32'h0);
        checkOutput("reset_mem_write_data", mem_write_data, 32'h0);
        checkOutput("reset_dmem_rdata", dmem_rdata, 32'h0);
        checkBit("reset_error", error, 1'b0);

        $display("[TB] directed read");
        memArr[32'h104] = 32'hCAFEF00D;
        s0 = stallCycles; r0 = readCycles;
        addTxn(32'h104, 4'h0, $urandom, 0, 0, -1, 1'b0);
        addGap(1);
        applyStimulus();
        checkOutput("read_addr", lastReadAddr, 32'h104);
        checkOutput("read_rdata", dmem_rdata, 32'hCAFEF00D);
        checkOutput("read_stall_cycles", stallCycles - s0, 2);
        checkOutput("read_bus_cycles", readCycles - r0, 1);

        $display("[TB] directed partial write");
        memArr[32'h200] = 32'h11223344;
        s0 = stallCycles; r0 = readCycles; w0 = writeCycles;
        addTxn(32'h203, 4'b0010, 32'h0000AB00, 0, 0, -1, 1'b0);
        addGap(1);
        applyStimulus();
        checkOutput("pw_addr", lastWriteAddr, 32'h200);
        checkOutput("pw_data", lastWriteData, 32'h1122AB44);
        checkOutput("pw_stall_cycles", stallCycles - s0, 3);
        checkOutput("pw_read_cycles", readCycles - r0, 1);
        checkOutput("pw_write_cycles", writeCycles - w0, 1);

        $display("[TB] directed full write with delayed response");
        s0 = stallCycles; r0 = readCycles; w0 = writeCycles;
        addTxn(32'h300, 4'hF, 32'h5A5A0F0F, 0, 5, -1, 1'b0);
        addGap(1);
        applyStimulus();
        checkOutput("fw_write_cycles", writeCycles - w0, 6);
        checkOutput("fw_read_cycles", readCycles - r0, 0);
        checkOutput("fw_stall_cycles", stallCycles - s0, 7);
        checkOutput("fw_data", lastWriteData, 32'h5A5A0F0F);

        $display("[TB] directed back-to-back reads");
        r0 = readCycles;
        addTxn(32'h400, 4'h0, $urandom, 0, 0, -1, 1'b1);
        addTxn(32'h404, 4'h0, $urandom, 0, 0, -1, 1'b0);
        addGap(1);
        applyStimulus();
        checkOutput("b2b_read_cycles", readCycles - r0, 2);
        checkOutput("b2b_idle_gap", lastGap, 2);

        $display("[TB] directed read timeout");
        r0 = readCycles;
        addTxn(32'h500, 4'h0, $urandom, 20, 0, -1, 1'b0);
        addGap(2);
        applyStimulus();
        checkOutput("tmo_read_cycles", readCycles - r0, 8);
        checkBit("tmo_error", error, 1'b1);
        checkOutput("tmo_rdata", dmem_rdata, 32'hDEADBEEF);
        checkBit("tmo_idle_stall", stall, 1'b0);

        $display("[TB] directed reset during write");
        w0 = writeCycles;
        addTxn(32'h600, 4'hF, $urandom, 0, 5, 2, 1'b0);
        addGap(1);
        applyStimulus();
        checkOutput("rst_write_cycles", writeCycles - w0, 3);
        checkBit("rst_error", error, 1'b0);
        checkBit("rst_mem_write", mem_write, 1'b0);
        checkOutput("rst_mem_address", mem_address, 32'h0);
        checkOutput("rst_rdata", dmem_rdata, 32'h0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) strb = 4'h0;
            else if (kind == 1) strb = 4'hF;
            else strb = 4'($urandom_range(1, 14));
            addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) addReset();
            addTxn(addr, strb, $urandom, pickDelay(), pickDelay(),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1,
                   1'($urandom_range(0, 1)));
            addGap(int'($urandom_range(0, 2)));
            applyStimulus();
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
